// File: rtl/ddr_app_initiator_if.sv
// Handshake bundle between the tile request/response channels, the initiator and
// the DDR controller app_* port. master = initiator view, slave = environment view.
interface ddr_app_initiator_if #(
    parameter int unsigned ADDR_WIDTH = 28,
    parameter int unsigned DATA_WIDTH = 64
) ();
    // Tile request channel
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_data;
    logic [DATA_WIDTH/8-1:0] req_wstrb;
    // Tile response channel
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_WIDTH-1:0]   rsp_data;
    // Controller command channel
    logic [ADDR_WIDTH-1:0]   app_addr;
    logic [2:0]              app_cmd;
    logic                    app_en;
    logic                    app_rdy;
    // Controller write-data channel
    logic [DATA_WIDTH-1:0]   app_wdf_data;
    logic [DATA_WIDTH/8-1:0] app_wdf_mask;
    logic                    app_wdf_wren;
    logic                    app_wdf_end;
    logic                    app_wdf_rdy;
    // Controller read return
    logic [DATA_WIDTH-1:0]   app_rd_data;
    logic                    app_rd_data_valid;
    logic                    app_rd_data_end;

    modport master (
        input  req_valid, req_write, req_addr, req_data, req_wstrb, rsp_ready,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
        output req_ready, rsp_valid, rsp_data,
        output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
    );

    modport slave (
        output req_valid, req_write, req_addr, req_data, req_wstrb, rsp_ready,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
        input  req_ready, rsp_valid, rsp_data,
        input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
    );
endinterface

// File: rtl/ddr_app_initiator.sv
// DDR controller app-interface initiator: one tile request at a time is turned into
// command / write-data handshakes; reads are credit limited and returned in order
// through a response FIFO. Optional feature macro DDR_APP_INITIATOR_STATS_EN adds
// saturating read/write command counters.
module ddr_app_initiator #(
    parameter int unsigned ADDR_WIDTH      = 28,
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 init_calib_complete,
    ddr_app_initiator_if.master  bus,
    output logic                 busy,
    output logic                 err_unexp_rd
`ifdef DDR_APP_INITIATOR_STATS_EN
    ,
    output logic [31:0]          stat_rd_cnt,
    output logic [31:0]          stat_wr_cnt
`endif
);

    localparam int unsigned MaskW = DATA_WIDTH / 8;
    localparam int unsigned PtrW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CntW  = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

    state_e              state_q;
    logic                app_en_q;
    logic                app_wdf_wren_q;
    logic [2:0]          app_cmd_q;
    logic [ADDR_WIDTH-1:0] app_addr_q;
    logic [DATA_WIDTH-1:0] wdf_data_q;
    logic [MaskW-1:0]    wdf_mask_q;

    logic [CntW-1:0]     credits_q;
    logic [CntW-1:0]     pending_q;
    logic [CntW-1:0]     fifo_cnt_q;
    logic [PtrW-1:0]     wr_ptr_q;
    logic [PtrW-1:0]     rd_ptr_q;
    logic [DATA_WIDTH-1:0] fifo_mem_q [MAX_OUTSTANDING];
    logic                err_q;

    logic req_ready;
    logic req_fire;
    logic cmd_fire;
    logic wdf_fire;
    logic rd_cmd_fire;
    logic rsp_valid;
    logic rsp_fire;
    logic rd_expected;
    logic rd_push;
    logic rd_unexp;
    logic unused_rd_end;

    // Handshake decode; req_ready is gated by rstn so every output is low during reset.
    always_comb begin
        req_ready   = rstn & (state_q == StIdle) & init_calib_complete &
                      (credits_q < CntW'(MAX_OUTSTANDING));
        req_fire    = bus.req_valid & req_ready;
        cmd_fire    = app_en_q & bus.app_rdy;
        wdf_fire    = app_wdf_wren_q & bus.app_wdf_rdy;
        rd_cmd_fire = cmd_fire & (state_q == StRd);
        rsp_valid   = (fifo_cnt_q != '0);
        rsp_fire    = rsp_valid & bus.rsp_ready;
        rd_expected = (pending_q != '0) | rd_cmd_fire;
        rd_push     = bus.app_rd_data_valid & rd_expected;
        rd_unexp    = bus.app_rd_data_valid & ~rd_expected;
    end

    assign unused_rd_end    = bus.app_rd_data_end;

    assign bus.req_ready    = req_ready;
    assign bus.rsp_valid    = rsp_valid;
    assign bus.rsp_data     = fifo_mem_q[rd_ptr_q];
    assign bus.app_addr     = app_addr_q;
    assign bus.app_cmd      = app_cmd_q;
    assign bus.app_en       = app_en_q;
    assign bus.app_wdf_data = wdf_data_q;
    assign bus.app_wdf_mask = wdf_mask_q;
    assign bus.app_wdf_wren = app_wdf_wren_q;
    assign bus.app_wdf_end  = app_wdf_wren_q;
    assign busy             = (state_q != StIdle) | (pending_q != '0);
    assign err_unexp_rd     = err_q;

    // Request FSM with registered app command / write-data outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= StIdle;
            app_en_q       <= 1'b0;
            app_wdf_wren_q <= 1'b0;
            app_cmd_q      <= 3'b000;
            app_addr_q     <= '0;
            wdf_data_q     <= '0;
            wdf_mask_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_fire) begin
                        app_addr_q <= bus.req_addr;
                        wdf_data_q <= bus.req_data;
                        wdf_mask_q <= ~bus.req_wstrb;
                        app_en_q   <= 1'b1;
                        if (bus.req_write) begin
                            app_cmd_q      <= 3'b000;
                            app_wdf_wren_q <= 1'b1;
                            state_q        <= StWr;
                        end else begin
                            app_cmd_q <= 3'b001;
                            state_q   <= StRd;
                        end
                    end
                end
                StRd: begin
                    if (cmd_fire) begin
                        app_en_q <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                StWr: begin
                    // Command and data channels complete independently, in either order.
                    if (cmd_fire) app_en_q <= 1'b0;
                    if (wdf_fire) app_wdf_wren_q <= 1'b0;
                    if ((cmd_fire | ~app_en_q) & (wdf_fire | ~app_wdf_wren_q)) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Read credits (issued, not yet consumed) and reads awaiting controller data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            credits_q <= '0;
            pending_q <= '0;
        end else begin
            if (rd_cmd_fire && !rsp_fire) begin
                credits_q <= credits_q + CntW'(1);
            end else if (!rd_cmd_fire && rsp_fire) begin
                credits_q <= credits_q - CntW'(1);
            end
            if (rd_cmd_fire && !rd_push) begin
                pending_q <= pending_q + CntW'(1);
            end else if (!rd_cmd_fire && rd_push) begin
                pending_q <= pending_q - CntW'(1);
            end
        end
    end

    // Response FIFO; credits guarantee it never overflows.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else begin
            if (rd_push) begin
                fifo_mem_q[wr_ptr_q] <= bus.app_rd_data;
                wr_ptr_q             <= wr_ptr_q + PtrW'(1);
            end
            if (rsp_fire) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (rd_push && !rsp_fire) begin
                fifo_cnt_q <= fifo_cnt_q + CntW'(1);
            end else if (!rd_push && rsp_fire) begin
                fifo_cnt_q <= fifo_cnt_q - CntW'(1);
            end
        end
    end

    // Sticky flag for read data arriving with nothing outstanding.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else if (rd_unexp) begin
            err_q <= 1'b1;
        end
    end

`ifdef DDR_APP_INITIATOR_STATS_EN
    logic        wr_cmd_fire;
    logic [31:0] stat_rd_q;
    logic [31:0] stat_wr_q;

    assign wr_cmd_fire = cmd_fire & (state_q == StWr);
    assign stat_rd_cnt = stat_rd_q;
    assign stat_wr_cnt = stat_wr_q;

    // Saturating command counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_rd_q <= '0;
            stat_wr_q <= '0;
        end else begin
            if (rd_cmd_fire && (stat_rd_q != 32'hFFFF_FFFF)) stat_rd_q <= stat_rd_q + 32'd1;
            if (wr_cmd_fire && (stat_wr_q != 32'hFFFF_FFFF)) stat_wr_q <= stat_wr_q + 32'd1;
        end
    end
`endif

endmodule
